s_io_regs: RTL
==============

Name: s_io_regs

Overview:
- Memory-mapped I/O responder for the SPC700 bus: decodes $00F0–$00FF, returns read data combinationally, and applies write and read-side effects on cpu_en strobes.
- Holds CONTROL, DSPADDR, the four host mailbox ports in each direction, and three timers (target, stage-2 divider, 4-bit read-clear counter).
- Sits beside ARAM in the APU top; the APU mux selects io_rdata when io_sel=1.

Parameters:
- DIV_FAST, 16, cpu_en pulses per timer-2 tick (1.024 MHz → 64 kHz).
- DIV_SLOW, 128, cpu_en pulses per timer-0/1 tick (→ 8 kHz); must be a multiple of DIV_FAST.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_en  in  1  SPC700 cycle strobe; all state updates are qualified by it
- mem_addr  in  16  CPU address
- mem_wdata  in  8  CPU write data
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- io_sel  out  1  comb: mem_addr in $00F0–$00FF
- ipl_sel  out  1  comb: IPL ROM overlay selected (see Optional Feature)
- io_rdata  out  8  comb read data
- host_addr  in  2  main-CPU port index
- host_wdata  in  8  main-CPU write data
- host_write  in  1  main-CPU write strobe (one clk, not gated by cpu_en)
- host_rdata  out  8  comb: cpuio_out[host_addr]
- dsp_addr  out  7  DSPADDR[6:0]
- dsp_wdata  out  8  DSP write data
- dsp_write  out  1  one-cycle DSP write pulse
- dsp_rdata  in  8  DSP register read data

Behaviour:
- Reset values: CONTROL=$80; DSPADDR=0; cpuio_in[0..3]=0; cpuio_out[0..3]=0; targets=0; stage-2 counters=0; out counters=0; prescaler=0; dsp_write=0.
- A read "takes effect" when cpu_en & mem_read & io_sel; a write when cpu_en & mem_write & io_sel. Read data has zero-cycle latency (comb), and side effects land at that edge.
- Read map:
  - F0 → $00; F1 → $00 (CONTROL is write-only).
  - F2 → DSPADDR; F3 → dsp_rdata.
  - F4–F7 → cpuio_in[n]; F8/F9 → scratch regs.
  - FA–FC → $00.
  - FD–FF → {4'h0, counter n}.
- Write map:
  - F0 is ignored.
  - F1 writes CONTROL.
    - Bits 2:0 are timer enables; a 0→1 edge clears that timer's stage-2 and out counter.
    - Bit 4 clears cpuio_in[0:1]; bit 5 clears cpuio_in[2:3]. Bits 4/5 are not stored.
    - Bit 7 is the IPL enable.
  - F2 writes DSPADDR (8 bits).
  - F3: dsp_write pulses for one clk with dsp_wdata=mem_wdata, only if DSPADDR[7]=0.
  - F4–F7 write cpuio_out[n]; F8/F9 write scratch; FA–FC write target n; FD–FF are ignored.
- Host writes set cpuio_in[host_addr]. If a host write and a CONTROL clear hit the same port in the same clk, the host write wins.
- Prescaler:
  - Counts cpu_en pulses and wraps at DIV_SLOW.
  - tick_fast fires when count mod DIV_FAST = DIV_FAST−1; tick_slow fires at DIV_SLOW−1.
  - Timer 0/1 use tick_slow; timer 2 uses tick_fast.
- Timer n, on each tick while enabled:
  - The stage-2 counter increments.
  - If the new value equals target (target $00 = 256), stage-2 returns to 0 and the out counter increments, modulo 16.
  - Disabling a timer freezes both counters.
- Read of FD–FF returns the old value; the counter becomes 0, or 1 if an increment lands in the same cycle (the increment is never lost).
- Writes with cpu_en=0 are ignored; mem_read & mem_write together is treated as a write.
- Asserting reset_n mid-operation clears everything immediately, independent of clk.

Optional Feature:
- Macro: S_IO_IPL_EN.
- Defined: ipl_sel = mem_read & CONTROL[7] & (mem_addr ≥ $FFC0). The APU muxes IPL ROM for those reads; writes always go to ARAM.
- Undefined: ipl_sel tied 0 and CONTROL[7] not stored (boot image preloaded in ARAM).

Test Plan:
- Reset then read F4–F7 and FD–FF → all $00. Host write port 2=$AA → CPU read F6=$AA. CPU write F5=$55 → host_rdata with host_addr=1 is $55.
- Write FA=$02, F1=$01, then run 2·2·DIV_SLOW cpu_en pulses → FD reads $02, and an immediate second read returns $00.
- FC=$00 (256), timer 2 on, run 256·DIV_FAST·17 pulses → FF reads $01 (out counter wrapped 16→0 then +1).
- Write F2=$8C then F3=$7F → no dsp_write. Write F2=$0C then F3=$7F → one dsp_write, dsp_addr=$0C, dsp_wdata=$7F. F2 reads $0C.
- Host write port 0=$11 in the same clk as CPU writes F1=$10 → cpuio_in[0]=$11 and cpuio_in[1]=$00.
- With S_IO_IPL_EN: read $FFC0 → ipl_sel=1. Write F1=$00, read $FFC0 → ipl_sel=0.

Source files
------------

// File: rtl/s_io_regs.sv
// SPC700 I/O register block at $00F0-$00FF: control, DSP address/data port,
// host mailboxes, scratch and three timers. Optional IPL overlay: S_IO_IPL_EN.
module s_io_regs #(
  parameter int DIV_FAST = 16,
  parameter int DIV_SLOW = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        io_sel,
  output logic        ipl_sel,
  output logic [7:0]  io_rdata,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_wdata,
  input  logic        host_write,
  output logic [7:0]  host_rdata,
  output logic [6:0]  dsp_addr,
  output logic [7:0]  dsp_wdata,
  output logic        dsp_write,
  input  logic [7:0]  dsp_rdata
);

  localparam int PW = $clog2(DIV_SLOW);

  logic [PW-1:0] presc;
  logic [2:0]    timer_en;
  logic [7:0]    dspaddr;
  logic [7:0]    cpuio_in  [4];
  logic [7:0]    cpuio_out [4];
  logic [7:0]    scratch   [2];
  logic [7:0]    target    [3];
  logic [7:0]    stage2    [3];
  logic [3:0]    out_cnt   [3];

  logic [3:0] reg_idx;
  logic       wr_take, rd_take, ctrl_wr;
  logic       tick_fast, tick_slow;
  logic [2:0] tick, run, hit, clr, en_rise;
  logic [7:0] stage_inc [3];

  assign io_sel     = (mem_addr[15:4] == 12'h00F);
  assign reg_idx    = mem_addr[3:0];
  // A simultaneous read+write request is handled as a write only.
  assign wr_take    = cpu_en & mem_write & io_sel;
  assign rd_take    = cpu_en & mem_read & ~mem_write & io_sel;
  assign ctrl_wr    = wr_take & (reg_idx == 4'h1);
  assign dsp_addr   = dspaddr[6:0];
  assign host_rdata = cpuio_out[host_addr];

  assign tick_fast = cpu_en & ((32'(presc) % DIV_FAST) == DIV_FAST - 1);
  assign tick_slow = cpu_en & (presc == PW'(DIV_SLOW - 1));
  assign tick      = {tick_fast, tick_slow, tick_slow};

`ifdef S_IO_IPL_EN
  logic ipl_en;
  assign ipl_sel = mem_read & ipl_en & (mem_addr >= 16'hFFC0);
`else
  assign ipl_sel = 1'b0;
`endif

  // Target $00 means 256: the 8-bit increment wraps to 0 and matches.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      stage_inc[n] = stage2[n] + 8'd1;
      run[n]       = tick[n] & timer_en[n];
      hit[n]       = run[n] & (stage_inc[n] == target[n]);
      clr[n]       = rd_take & (reg_idx == 4'(13 + n));
      en_rise[n]   = ctrl_wr & mem_wdata[n] & ~timer_en[n];
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    if (io_sel) begin
      case (reg_idx)
        4'h2:                      io_rdata = dspaddr;
        4'h3:                      io_rdata = dsp_rdata;
        4'h4, 4'h5, 4'h6, 4'h7:    io_rdata = cpuio_in[reg_idx[1:0]];
        4'h8, 4'h9:                io_rdata = scratch[reg_idx[0]];
        4'hD:                      io_rdata = {4'h0, out_cnt[0]};
        4'hE:                      io_rdata = {4'h0, out_cnt[1]};
        4'hF:                      io_rdata = {4'h0, out_cnt[2]};
        default:                   io_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      timer_en  <= 3'b000;
      dspaddr   <= 8'h00;
      dsp_wdata <= 8'h00;
      dsp_write <= 1'b0;
`ifdef S_IO_IPL_EN
      ipl_en    <= 1'b1;
`endif
      for (int i = 0; i < 4; i++) begin
        cpuio_in[i]  <= 8'h00;
        cpuio_out[i] <= 8'h00;
      end
      for (int i = 0; i < 2; i++) scratch[i] <= 8'h00;
      for (int i = 0; i < 3; i++) begin
        target[i]  <= 8'h00;
        stage2[i]  <= 8'h00;
        out_cnt[i] <= 4'h0;
      end
    end else begin
      dsp_write <= 1'b0;
      if (cpu_en) presc <= tick_slow ? '0 : presc + 1'b1;

      for (int n = 0; n < 3; n++) begin
        if (en_rise[n]) begin
          stage2[n]  <= 8'h00;
          out_cnt[n] <= 4'h0;
        end else begin
          if (run[n]) stage2[n] <= hit[n] ? 8'h00 : stage_inc[n];
          // Read-clear keeps a coincident increment.
          if (clr[n])      out_cnt[n] <= {3'b000, hit[n]};
          else if (hit[n]) out_cnt[n] <= out_cnt[n] + 4'd1;
        end
      end

      if (wr_take) begin
        case (reg_idx)
          4'h1: begin
            timer_en <= mem_wdata[2:0];
`ifdef S_IO_IPL_EN
            ipl_en   <= mem_wdata[7];
`endif
          end
          4'h2: dspaddr <= mem_wdata;
          4'h3: if (!dspaddr[7]) begin
            dsp_write <= 1'b1;
            dsp_wdata <= mem_wdata;
          end
          4'h4, 4'h5, 4'h6, 4'h7: cpuio_out[reg_idx[1:0]] <= mem_wdata;
          4'h8, 4'h9:             scratch[reg_idx[0]] <= mem_wdata;
          4'hA: target[0] <= mem_wdata;
          4'hB: target[1] <= mem_wdata;
          4'hC: target[2] <= mem_wdata;
          default: ;
        endcase
      end

      // Host write beats a CONTROL clear of the same port.
      for (int p = 0; p < 4; p++) begin
        if (host_write && (host_addr == 2'(p)))       cpuio_in[p] <= host_wdata;
        else if (ctrl_wr && mem_wdata[4 + (p / 2)])   cpuio_in[p] <= 8'h00;
      end
    end
  end

endmodule
